// File: rtl/tagged_scoreboard.sv
// Age-ordered tagged instruction scoreboard.
// Tracks in-flight entries, detects RAW/WAW hazards, issues oldest ready entry.
module tagged_scoreboard #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32,
   parameter int TAGW  = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [XLEN-1:0]            push_instr,
   input  logic [XLEN-1:0]            push_pc,
   input  logic [4:0]                 push_rd,
   input  logic [4:0]                 push_rs1,
   input  logic [4:0]                 push_rs2,
   input  logic                       push_multicycle,
   output logic [TAGW-1:0]            push_tag,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [XLEN-1:0]            issue_instr,
   output logic [XLEN-1:0]            issue_pc,
   output logic [TAGW-1:0]            issue_tag,
   input  logic                       complete_valid,
   input  logic [TAGW-1:0]            complete_tag,
   input  logic                       flush_valid,
   input  logic [TAGW-1:0]            flush_tag,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic            mc;
      logic            run;
      logic [TAGW-1:0] tag;
   } ent_t;

   ent_t            ent_q [DEPTH];
   ent_t            ent_d [DEPTH];
   logic [CW-1:0]   count_q, count_d;
   logic [TAGW-1:0] tag_q, tag_d;

   logic [DEPTH-1:0] live, hazard, cand, sel, keep;
   logic             tag_busy, found, push_fire, issue_fire;
   logic             flush_hit;
   logic [CW-1:0]    kept;
   ent_t             cur, push_ent;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         live[i]   = CW'(i) < count_q;
         hazard[i] = 1'b0;
         for (int j = 0; j < i; j++) begin
            if (live[j]) begin
               // a single-cycle producer already running no longer blocks readers
               if (ent_q[i].rs1 != '0 && ent_q[j].rd == ent_q[i].rs1 &&
                   (!ent_q[j].run || ent_q[j].mc))
                  hazard[i] = 1'b1;
               if (ent_q[i].rs2 != '0 && ent_q[j].rd == ent_q[i].rs2 &&
                   (!ent_q[j].run || ent_q[j].mc))
                  hazard[i] = 1'b1;
               if (ent_q[i].rd != '0 && ent_q[j].rd == ent_q[i].rd &&
                   !ent_q[j].run)
                  hazard[i] = 1'b1;
            end
         end
         cand[i] = live[i] && !ent_q[i].run && !hazard[i];
      end
   end

   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (cand[i] && !found) begin
            sel[i] = 1'b1;
            found  = 1'b1;
         end
      end
      if (flush_valid)
         sel = '0;
      issue_valid = |sel;
      issue_instr = '0;
      issue_pc    = '0;
      issue_tag   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel[i]) begin
            issue_instr = issue_instr | ent_q[i].instr;
            issue_pc    = issue_pc | ent_q[i].pc;
            issue_tag   = issue_tag | ent_q[i].tag;
         end
      end
   end

   always_comb begin
      tag_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (live[i] && ent_q[i].tag == tag_q)
            tag_busy = 1'b1;
   end

   assign push_ready = (count_q < CW'(DEPTH)) && !flush_valid && !tag_busy;
   assign push_fire  = push_valid && push_ready;
   assign issue_fire = issue_valid && issue_ready;
   assign push_tag   = tag_q;

   always_comb begin
      flush_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         // flush removes the matching entry and everything younger
         if (flush_valid && live[i] && ent_q[i].tag == flush_tag)
            flush_hit = 1'b1;
         keep[i] = live[i] && !flush_hit &&
                   !(complete_valid && ent_q[i].run &&
                     ent_q[i].tag == complete_tag);
      end
   end

   always_comb begin
      push_ent.instr = push_instr;
      push_ent.pc    = push_pc;
      push_ent.rd    = push_rd;
      push_ent.rs1   = push_rs1;
      push_ent.rs2   = push_rs2;
      push_ent.mc    = push_multicycle;
      push_ent.run   = 1'b0;
      push_ent.tag   = tag_q;
      kept = '0;
      cur  = '0;
      for (int k = 0; k < DEPTH; k++)
         ent_d[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cur = ent_q[i];
         if (issue_fire && sel[i])
            cur.run = 1'b1;
         for (int k = 0; k < DEPTH; k++)
            if (keep[i] && kept == CW'(k))
               ent_d[k] = cur;
         if (keep[i])
            kept = kept + CW'(1);
      end
      for (int k = 0; k < DEPTH; k++)
         if (push_fire && kept == CW'(k))
            ent_d[k] = push_ent;
      count_d = kept + CW'(push_fire);
      tag_d   = push_fire ? tag_q + TAGW'(1) : tag_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
         tag_q   <= '0;
         for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= '0;
      end else begin
         count_q <= count_d;
         tag_q   <= tag_d;
         for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= ent_d[i];
      end
   end

   assign count = count_q;
   assign full  = count_q == CW'(DEPTH);
   assign empty = count_q == '0;

endmodule

// File: tb/tb_tagged_scoreboard.sv
// Self-checking bench for tagged_scoreboard.
// Expected issue records are queued at stimulus time and popped on handshakes.
module tb_tagged_scoreboard;

   logic        clock = 1'b0;
   logic        reset;
   logic        push_valid, push_multicycle, issue_ready;
   logic [31:0] push_instr, push_pc;
   logic [4:0]  push_rd, push_rs1, push_rs2;
   logic        complete_valid, flush_valid;
   logic [3:0]  complete_tag, flush_tag;

   logic        push_ready, issue_valid, full, empty;
   logic [3:0]  push_tag, issue_tag, count;
   logic [31:0] issue_instr, issue_pc;

   logic        w_push_ready, w_issue_valid, w_full, w_empty;
   logic [2:0]  w_push_tag, w_issue_tag;
   logic [3:0]  w_count;
   logic [31:0] w_issue_instr, w_issue_pc;

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] pc;
      logic [31:0] instr;
   } rec_t;

   rec_t       exp_q [$];
   rec_t       r;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] tb_tag;

   always #5 clock = ~clock;

   tagged_scoreboard #(.DEPTH(8), .XLEN(32), .TAGW(4)) dut (
      .clock(clock), .reset(reset),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_instr(push_instr), .push_pc(push_pc),
      .push_rd(push_rd), .push_rs1(push_rs1), .push_rs2(push_rs2),
      .push_multicycle(push_multicycle), .push_tag(push_tag),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_instr(issue_instr), .issue_pc(issue_pc),
      .issue_tag(issue_tag),
      .complete_valid(complete_valid), .complete_tag(complete_tag),
      .flush_valid(flush_valid), .flush_tag(flush_tag),
      .count(count), .full(full), .empty(empty)
   );

   tagged_scoreboard #(.DEPTH(8), .XLEN(32), .TAGW(3)) dut_w (
      .clock(clock), .reset(reset),
      .push_valid(push_valid), .push_ready(w_push_ready),
      .push_instr(push_instr), .push_pc(push_pc),
      .push_rd(push_rd), .push_rs1(push_rs1), .push_rs2(push_rs2),
      .push_multicycle(push_multicycle), .push_tag(w_push_tag),
      .issue_valid(w_issue_valid), .issue_ready(issue_ready),
      .issue_instr(w_issue_instr), .issue_pc(w_issue_pc),
      .issue_tag(w_issue_tag),
      .complete_valid(complete_valid), .complete_tag(complete_tag[2:0]),
      .flush_valid(flush_valid), .flush_tag(flush_tag[2:0]),
      .count(w_count), .full(w_full), .empty(w_empty)
   );

   function automatic rec_t mk(input logic [3:0] t);
      rec_t x;
      x.tag   = t;
      x.pc    = 32'h1000 + {26'd0, t, 2'b00};
      x.instr = 32'h13 | {8'd0, t, 20'd0};
      return x;
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      push_valid     = 1'b0;
      issue_ready    = 1'b0;
      complete_valid = 1'b0;
      flush_valid    = 1'b0;
   endtask

   task automatic push_in(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic mc);
      rec_t x;
      x = mk(tb_tag);
      push_valid      = 1'b1;
      push_rd         = rd;
      push_rs1        = rs1;
      push_rs2        = rs2;
      push_multicycle = mc;
      push_pc         = x.pc;
      push_instr      = x.instr;
      tb_tag          = tb_tag + 4'd1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      exp_q.delete();
      tb_tag = 4'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      push_valid = 1'b1;
      issue_ready = 1'b1;
      complete_valid = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      idle();
      #1;
      checks++;
      if ({count, empty, full, issue_valid, push_tag, push_ready} !==
          {4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: got cnt=%0d e=%b f=%b iv=%b pt=%0d pr=%b",
                  count, empty, full, issue_valid, push_tag, push_ready);
      end
      checks++;
      if ({issue_instr, issue_pc, issue_tag} !== 68'd0) begin
         errors++;
         $display("FAIL reset_issue_data: got %h %h %h want 0",
                  issue_instr, issue_pc, issue_tag);
      end
      checks++;
      if ({w_count, w_empty, w_push_ready} !== {4'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL reset_w: got cnt=%0d e=%b pr=%b want 0 1 1",
                  w_count, w_empty, w_push_ready);
      end
   endtask

   task automatic test_raw_single();
      do_reset();
      push_in(5'd1, 5'd0, 5'd0, 1'b0);
      exp_q.push_back(mk(4'd0));
      exp_q.push_back(mk(4'd1));
      cyc();
      push_in(5'd2, 5'd1, 5'd0, 1'b0);
      #1;
      checks++;
      if ({issue_valid, issue_tag} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL raw_present_a: got v=%b t=%0d want 1 0",
                  issue_valid, issue_tag);
      end
      cyc();
      push_valid = 1'b0;
      issue_ready = 1'b1;
      #1;
      r = exp_q.pop_front();
      checks++;
      if ({issue_valid, issue_tag, issue_pc, issue_instr} !== {1'b1, r}) begin
         errors++;
         $display("FAIL raw_issue_a: got t=%0d pc=%h want t=%0d pc=%h",
                  issue_tag, issue_pc, r.tag, r.pc);
      end
      cyc();
      r = exp_q.pop_front();
      checks++;
      if ({issue_valid, issue_tag, issue_pc, issue_instr} !== {1'b1, r}) begin
         errors++;
         $display("FAIL raw_issue_b: got v=%b t=%0d want t=%0d",
                  issue_valid, issue_tag, r.tag);
      end
      cyc();
      issue_ready = 1'b0;
      #1;
      checks++;
      if ({issue_valid, count} !== {1'b0, 4'd2}) begin
         errors++;
         $display("FAIL raw_running: got v=%b cnt=%0d want 0 2",
                  issue_valid, count);
      end
      complete_valid = 1'b1;
      complete_tag = 4'd0;
      cyc();
      complete_tag = 4'd1;
      cyc();
      complete_valid = 1'b0;
      #1;
      checks++;
      if ({count, empty} !== {4'd0, 1'b1}) begin
         errors++;
         $display("FAIL raw_drain: got cnt=%0d e=%b want 0 1", count, empty);
      end
   endtask

   task automatic test_multicycle();
      do_reset();
      issue_ready = 1'b1;
      push_in(5'd3, 5'd0, 5'd0, 1'b1);
      exp_q.push_back(mk(4'd0));
      cyc();
      push_in(5'd0, 5'd0, 5'd3, 1'b0);
      #1;
      r = exp_q.pop_front();
      checks++;
      if ({issue_valid, issue_tag, issue_pc, issue_instr} !== {1'b1, r}) begin
         errors++;
         $display("FAIL mc_issue_a: got v=%b t=%0d want t=%0d",
                  issue_valid, issue_tag, r.tag);
      end
      cyc();
      push_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL mc_hold_%0d: got v=%b want 0", i, issue_valid);
         end
         cyc();
      end
      complete_valid = 1'b1;
      complete_tag = 4'd1;
      cyc();
      complete_tag = 4'd5;
      cyc();
      complete_valid = 1'b0;
      #1;
      checks++;
      if ({count, issue_valid} !== {4'd2, 1'b0}) begin
         errors++;
         $display("FAIL mc_ignore_cmpl: got cnt=%0d v=%b want 2 0",
                  count, issue_valid);
      end
      complete_valid = 1'b1;
      complete_tag = 4'd0;
      #1;
      checks++;
      if (issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL mc_no_bypass: got v=%b want 0", issue_valid);
      end
      exp_q.push_back(mk(4'd1));
      cyc();
      complete_valid = 1'b0;
      #1;
      r = exp_q.pop_front();
      checks++;
      if ({issue_valid, issue_tag, issue_pc, issue_instr, count} !==
          {1'b1, r, 4'd1}) begin
         errors++;
         $display("FAIL mc_issue_b: got v=%b t=%0d cnt=%0d want t=%0d cnt=1",
                  issue_valid, issue_tag, count, r.tag);
      end
      cyc();
      issue_ready = 1'b0;
      complete_valid = 1'b1;
      complete_tag = 4'd1;
      cyc();
      complete_valid = 1'b0;
      push_in(5'd7, 5'd0, 5'd0, 1'b1);
      exp_q.push_back(mk(4'd2));
      cyc();
      issue_ready = 1'b1;
      push_in(5'd8, 5'd7, 5'd0, 1'b0);
      #1;
      r = exp_q.pop_front();
      checks++;
      if ({issue_valid, issue_tag, issue_pc, issue_instr} !== {1'b1, r}) begin
         errors++;
         $display("FAIL mix_issue_x: got t=%0d want t=%0d", issue_tag, r.tag);
      end
      cyc();
      issue_ready = 1'b0;
      push_in(5'd0, 5'd8, 5'd0, 1'b0);
      #1;
      checks++;
      if (issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL mix_y_blocked: got v=%b want 0", issue_valid);
      end
      cyc();
      push_in(5'd8, 5'd0, 5'd0, 1'b0);
      cyc();
      push_in(5'd9, 5'd0, 5'd0, 1'b0);
      cyc();
      push_valid = 1'b0;
      issue_ready = 1'b1;
      exp_q.push_back(mk(4'd6));
      #1;
      r = exp_q.pop_front();
      checks++;
      if ({issue_valid, issue_tag, issue_pc, issue_instr} !== {1'b1, r}) begin
         errors++;
         $display("FAIL mix_skip_to_v: got v=%b t=%0d want t=%0d",
                  issue_valid, issue_tag, r.tag);
      end
      cyc();
      issue_ready = 1'b0;
      complete_valid = 1'b1;
      complete_tag = 4'd2;
      cyc();
      complete_valid = 1'b0;
      issue_ready = 1'b1;
      exp_q.push_back(mk(4'd3));
      exp_q.push_back(mk(4'd4));
      exp_q.push_back(mk(4'd5));
      for (int i = 0; i < 3; i++) begin
         #1;
         r = exp_q.pop_front();
         checks++;
         if ({issue_valid, issue_tag, issue_pc, issue_instr} !==
             {1'b1, r}) begin
            errors++;
            $display("FAIL mix_order_%0d: got v=%b t=%0d want t=%0d",
                     i, issue_valid, issue_tag, r.tag);
         end
         cyc();
      end
      issue_ready = 1'b0;
      #1;
      checks++;
      if ({count, issue_valid} !== {4'd4, 1'b0}) begin
         errors++;
         $display("FAIL mix_final: got cnt=%0d v=%b want 4 0",
                  count, issue_valid);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         push_in(5'd0, 5'd0, 5'd0, 1'b0);
         cyc();
      end
      push_valid = 1'b0;
      #1;
      checks++;
      if ({full, push_ready, count, push_tag} !==
          {1'b1, 1'b0, 4'd8, 4'd8}) begin
         errors++;
         $display("FAIL full_state: got f=%b pr=%b cnt=%0d pt=%0d",
                  full, push_ready, count, push_tag);
      end
      issue_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         exp_q.push_back(mk(4'(t)));
         #1;
         r = exp_q.pop_front();
         checks++;
         if ({issue_valid, issue_tag, issue_pc, issue_instr} !==
             {1'b1, r}) begin
            errors++;
            $display("FAIL full_issue_%0d: got t=%0d want t=%0d",
                     t, issue_tag, r.tag);
         end
         cyc();
      end
      issue_ready = 1'b0;
      complete_valid = 1'b1;
      complete_tag = 4'd2;
      cyc();
      complete_valid = 1'b0;
      issue_ready = 1'b1;
      push_in(5'd0, 5'd0, 5'd0, 1'b0);
      exp_q.push_back(mk(4'd3));
      #1;
      checks++;
      if ({count, full, push_ready, push_tag} !==
          {4'd7, 1'b0, 1'b1, 4'd8}) begin
         errors++;
         $display("FAIL full_after_cmpl: got cnt=%0d f=%b pr=%b pt=%0d",
                  count, full, push_ready, push_tag);
      end
      r = exp_q.pop_front();
      checks++;
      if ({issue_valid, issue_tag, issue_pc, issue_instr} !== {1'b1, r}) begin
         errors++;
         $display("FAIL full_compact_issue: got t=%0d want t=%0d",
                  issue_tag, r.tag);
      end
      cyc();
      idle();
      #1;
      checks++;
      if ({count, full, push_tag} !== {4'd8, 1'b1, 4'd9}) begin
         errors++;
         $display("FAIL full_refill: got cnt=%0d f=%b pt=%0d want 8 1 9",
                  count, full, push_tag);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push_in(5'd0, 5'd0, 5'd0, 1'b0);
         cyc();
      end
      push_valid = 1'b0;
      issue_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         exp_q.push_back(mk(4'(t)));
         #1;
         r = exp_q.pop_front();
         checks++;
         if ({issue_valid, issue_tag, issue_pc, issue_instr} !==
             {1'b1, r}) begin
            errors++;
            $display("FAIL flush_issue_%0d: got t=%0d want t=%0d",
                     t, issue_tag, r.tag);
         end
         cyc();
      end
      issue_ready = 1'b1;
      flush_valid = 1'b1;
      flush_tag = 4'd2;
      complete_valid = 1'b1;
      complete_tag = 4'd3;
      push_valid = 1'b1;
      #1;
      checks++;
      if ({push_ready, issue_valid} !== 2'b00) begin
         errors++;
         $display("FAIL flush_suppress: got pr=%b iv=%b want 0 0",
                  push_ready, issue_valid);
      end
      cyc();
      idle();
      #1;
      checks++;
      if ({count, push_tag, issue_valid} !== {4'd2, 4'd5, 1'b0}) begin
         errors++;
         $display("FAIL flush_result: got cnt=%0d pt=%0d iv=%b want 2 5 0",
                  count, push_tag, issue_valid);
      end
      flush_valid = 1'b1;
      flush_tag = 4'd9;
      cyc();
      flush_valid = 1'b0;
      complete_valid = 1'b1;
      complete_tag = 4'd2;
      cyc();
      complete_valid = 1'b0;
      #1;
      checks++;
      if (count !== 4'd2) begin
         errors++;
         $display("FAIL flush_nomatch: got cnt=%0d want 2", count);
      end
      complete_valid = 1'b1;
      complete_tag = 4'd1;
      cyc();
      #1;
      checks++;
      if (count !== 4'd1) begin
         errors++;
         $display("FAIL flush_keep1: got cnt=%0d want 1", count);
      end
      complete_tag = 4'd0;
      cyc();
      complete_valid = 1'b0;
      tb_tag = 4'd5;
      push_in(5'd0, 5'd0, 5'd0, 1'b0);
      exp_q.push_back(mk(4'd5));
      cyc();
      push_valid = 1'b0;
      issue_ready = 1'b1;
      #1;
      r = exp_q.pop_front();
      checks++;
      if ({issue_valid, issue_tag, issue_pc, issue_instr, count} !==
          {1'b1, r, 4'd1}) begin
         errors++;
         $display("FAIL flush_next_push: got t=%0d cnt=%0d want t=%0d cnt=1",
                  issue_tag, count, r.tag);
      end
      cyc();
      issue_ready = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         push_in(5'd0, 5'd0, 5'd0, 1'b0);
         exp_q.push_back(mk(4'(i)));
         cyc();
      end
      push_valid = 1'b0;
      #1;
      checks++;
      if ({w_full, w_push_tag} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL wrap_full: got f=%b pt=%0d want 1 0",
                  w_full, w_push_tag);
      end
      issue_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         #1;
         r = exp_q.pop_front();
         checks++;
         if ({w_issue_valid, w_issue_tag, w_issue_pc, w_issue_instr} !==
             {1'b1, r.tag[2:0], r.pc, r.instr}) begin
            errors++;
            $display("FAIL wrap_issue_%0d: got v=%b t=%0d want t=%0d",
                     t, w_issue_valid, w_issue_tag, r.tag[2:0]);
         end
         cyc();
      end
      issue_ready = 1'b0;
      complete_valid = 1'b1;
      for (int t = 1; t < 8; t++) begin
         complete_tag = 4'(t);
         cyc();
      end
      complete_valid = 1'b0;
      push_valid = 1'b1;
      #1;
      checks++;
      if ({w_count, w_push_ready, w_push_tag} !== {4'd1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL wrap_blocked: got cnt=%0d pr=%b pt=%0d want 1 0 0",
                  w_count, w_push_ready, w_push_tag);
      end
      cyc();
      push_valid = 1'b0;
      complete_valid = 1'b1;
      complete_tag = 4'd0;
      #1;
      checks++;
      if ({w_count, w_push_ready} !== {4'd1, 1'b0}) begin
         errors++;
         $display("FAIL wrap_still_blocked: got cnt=%0d pr=%b want 1 0",
                  w_count, w_push_ready);
      end
      cyc();
      complete_valid = 1'b0;
      #1;
      checks++;
      if ({w_count, w_empty, w_push_ready} !== {4'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL wrap_released: got cnt=%0d e=%b pr=%b want 0 1 1",
                  w_count, w_empty, w_push_ready);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         push_in(5'd0, 5'd0, 5'd0, 1'b0);
         cyc();
      end
      push_valid = 1'b0;
      issue_ready = 1'b1;
      cyc();
      issue_ready = 1'b0;
      #1;
      checks++;
      if (full !== 1'b1) begin
         errors++;
         $display("FAIL rmid_full: got f=%b want 1", full);
      end
      reset = 1'b1;
      push_valid = 1'b1;
      complete_valid = 1'b1;
      complete_tag = 4'd0;
      cyc();
      reset = 1'b0;
      idle();
      #1;
      checks++;
      if ({count, empty, full, issue_valid, push_tag} !==
          {4'd0, 1'b1, 1'b0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL rmid_state: got cnt=%0d e=%b f=%b iv=%b pt=%0d",
                  count, empty, full, issue_valid, push_tag);
      end
      checks++;
      if ({issue_instr, issue_pc, issue_tag, push_ready} !== {68'd0, 1'b1}) begin
         errors++;
         $display("FAIL rmid_data: got %h %h %0d pr=%b want 0 0 0 1",
                  issue_instr, issue_pc, issue_tag, push_ready);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle();
      push_instr = '0;
      push_pc = '0;
      push_rd = '0;
      push_rs1 = '0;
      push_rs2 = '0;
      push_multicycle = 1'b0;
      complete_tag = '0;
      flush_tag = '0;
      tb_tag = 4'd0;
      test_reset();
      test_raw_single();
      test_multicycle();
      test_full();
      test_flush();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
